// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Each grant accepts up to MAX_BURST words, stalls on fifo_full and releases when the owner drops valid.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int BCNT_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wr,
  output logic [DATA_W-1:0]         o_fifo_din,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_owner, w_owner_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_inc;
  logic [ID_W-1:0]   w_pick_idx, w_cand;
  logic              w_pick_found;
  logic              w_busy, w_owner_valid, w_acc;

  assign w_busy        = (r_state == S_GRANT);
  assign w_owner_valid = i_req_valid[r_owner];
  // Gating with rst keeps a word presented during the reset cycle out of the FIFO.
  assign w_acc         = w_busy & w_owner_valid & ~i_fifo_full & ~rst;
  assign w_bcnt_inc    = r_bcnt + BCNT_W'(1);

  assign o_busy      = w_busy;
  assign o_grant_id  = r_owner;
  assign o_fifo_wr   = w_acc;
  assign o_fifo_din  = w_busy ? i_req_data[int'(r_owner)*DATA_W +: DATA_W] : '0;
  assign o_req_ready = w_acc ? (NUM_REQ'(1) << r_owner) : '0;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_pick_found && i_req_valid[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick_idx;
          w_bcnt_nxt  = '0;
          w_rr_nxt    = (w_pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + ID_W'(1);
        end
      end
      S_GRANT: begin
        if (!w_owner_valid) begin
          w_state_nxt = S_IDLE;
        end else if (w_acc) begin
          w_bcnt_nxt = w_bcnt_inc;
          if (w_bcnt_inc == BCNT_W'(MAX_BURST)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_bcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_bcnt   <= w_bcnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: per-cycle write/grant patterns per scenario,
// plus a scoreboard of expected FIFO words popped on every write strobe.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_q [4][$];
  logic [7:0] exp_q [$];
  logic [3:0] force_low  = 4'b0000;
  logic [3:0] ready_seen = 4'b0000;

  fifo_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_fifo_full (fifo_full),
    .o_fifo_wr   (fifo_wr),
    .o_fifo_din  (fifo_din),
    .o_grant_id  (grant_id),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (src_q[i].size() > 0) && !force_low[i];
      req_data[i*8 +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic load(input int p, input logic [7:0] w);
    src_q[p].push_back(w);
  endtask

  // Producers: pop the word that was accepted on the previous cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (ready_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    refresh();
  end

  // FIFO-side monitor and scoreboard.
  always @(negedge clk) begin
    ready_seen = req_ready;
    total++;
    if (!$onehot0(req_ready) || ((req_ready != 4'b0) !== fifo_wr) || (fifo_wr && fifo_full)) begin
      bad++;
      $display("FAIL port_consistency t=%0t ready=%b wr=%b full=%b", $time, req_ready, fifo_wr, fifo_full);
    end
    if (fifo_wr) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write t=%0t din=%h required=none", $time, fifo_din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (fifo_din !== e) begin
          bad++;
          $display("FAIL fifo_word t=%0t din=%h required=%h", $time, fifo_din, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    total++; if (fifo_wr !== 1'b0)  begin bad++; $display("FAIL reset_wr got=%b want=0", fifo_wr); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (fifo_din !== 8'h00) begin bad++; $display("FAIL reset_din got=%h want=00", fifo_din); end
    @(posedge clk); #2;
  endtask

  task automatic test_single();
    logic [8:0] wr_pat   = 9'b011011110;
    logic [8:0] busy_pat = 9'b111011110;
    for (int w = 1; w <= 6; w++) begin
      load(0, 8'(8'h10 + w));
      exp_q.push_back(8'(8'h10 + w));
    end
    refresh();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      total++; if (fifo_wr !== wr_pat[c]) begin bad++; $display("FAIL single_wr c=%0d got=%b want=%b", c, fifo_wr, wr_pat[c]); end
      total++; if (busy !== busy_pat[c]) begin bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, busy_pat[c]); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant c=%0d got=%0d want=0", c, grant_id); end
      total++; if (req_ready !== (wr_pat[c] ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_ready c=%0d got=%b", c, req_ready); end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_rotation();
    logic wr_exp;
    logic [1:0] g_exp;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int w = 0; w < 4; w++) begin
        load(p, 8'(8'h40 + p*16 + w));
        exp_q.push_back(8'(8'h40 + p*16 + w));
      end
    for (int w = 4; w < 8; w++) begin
      load(0, 8'(8'h40 + w));
      exp_q.push_back(8'(8'h40 + w));
    end
    refresh();
    for (int c = 0; c < 26; c++) begin
      wr_exp = (c % 5 != 0) && (c < 25);
      g_exp  = 2'((c / 5) % 4);
      @(negedge clk);
      total++; if (fifo_wr !== wr_exp) begin bad++; $display("FAIL rot_wr c=%0d got=%b want=%b", c, fifo_wr, wr_exp); end
      total++; if (busy !== wr_exp) begin bad++; $display("FAIL rot_busy c=%0d got=%b want=%b", c, busy, wr_exp); end
      if (wr_exp) begin
        total++; if (grant_id !== g_exp) begin bad++; $display("FAIL rot_grant c=%0d got=%0d want=%0d", c, grant_id, g_exp); end
        total++; if (req_ready !== (4'b0001 << g_exp)) begin bad++; $display("FAIL rot_ready c=%0d got=%b", c, req_ready); end
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_skip_wrap();
    logic [2:0] wr_a = 3'b010;
    logic [7:0] wr_b = 8'b01100110;
    load(2, 8'h60);
    exp_q.push_back(8'h60);
    refresh();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (fifo_wr !== wr_a[c]) begin bad++; $display("FAIL skip_a_wr c=%0d got=%b want=%b", c, fifo_wr, wr_a[c]); end
      if (c == 1) begin
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL skip_a_grant got=%0d want=2", grant_id); end
      end
      @(posedge clk); #2;
    end
    for (int w = 0; w < 2; w++) begin
      load(0, 8'(8'h61 + w)); load(1, 8'(8'h71 + w));
    end
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    refresh();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (fifo_wr !== wr_b[c]) begin bad++; $display("FAIL skip_b_wr c=%0d got=%b want=%b", c, fifo_wr, wr_b[c]); end
      if (wr_b[c]) begin
        total++;
        if (grant_id !== ((c < 4) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL skip_b_grant c=%0d got=%0d", c, grant_id); end
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_full_stall();
    logic [11:0] wr_pat   = 12'b001011000110;
    logic [11:0] busy_pat = 12'b011011111110;
    for (int w = 1; w <= 5; w++) begin
      load(2, 8'(8'h70 + w));
      exp_q.push_back(8'(8'h70 + w));
    end
    refresh();
    for (int c = 0; c < 12; c++) begin
      if (c == 3) fifo_full = 1'b1;
      if (c == 6) fifo_full = 1'b0;
      @(negedge clk);
      total++; if (fifo_wr !== wr_pat[c]) begin bad++; $display("FAIL stall_wr c=%0d got=%b want=%b", c, fifo_wr, wr_pat[c]); end
      total++; if (busy !== busy_pat[c]) begin bad++; $display("FAIL stall_busy c=%0d got=%b want=%b", c, busy, busy_pat[c]); end
      total++; if (req_ready !== (wr_pat[c] ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL stall_ready c=%0d got=%b", c, req_ready); end
      if (busy_pat[c]) begin
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL stall_grant c=%0d got=%0d want=2", c, grant_id); end
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_early_release();
    logic [12:0] wr_pat   = 13'b0011001100110;
    logic [12:0] busy_pat = 13'b0111011101110;
    logic [1:0]  g_exp;
    for (int w = 1; w <= 4; w++) load(3, 8'(8'h80 + w));
    load(0, 8'h91); load(0, 8'h92);
    exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    exp_q.push_back(8'h91); exp_q.push_back(8'h92);
    exp_q.push_back(8'h83); exp_q.push_back(8'h84);
    refresh();
    for (int c = 0; c < 13; c++) begin
      if (c == 3) begin force_low[3] = 1'b1; refresh(); end
      if (c == 4) begin force_low[3] = 1'b0; refresh(); end
      g_exp = (c >= 5 && c <= 7) ? 2'd0 : 2'd3;
      @(negedge clk);
      total++; if (fifo_wr !== wr_pat[c]) begin bad++; $display("FAIL early_wr c=%0d got=%b want=%b", c, fifo_wr, wr_pat[c]); end
      total++; if (busy !== busy_pat[c]) begin bad++; $display("FAIL early_busy c=%0d got=%b want=%b", c, busy, busy_pat[c]); end
      if (busy_pat[c]) begin
        total++; if (grant_id !== g_exp) begin bad++; $display("FAIL early_grant c=%0d got=%0d want=%0d", c, grant_id, g_exp); end
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [14:0] wr_pat   = 15'b001001100100110;
    logic [14:0] busy_pat = 15'b011011101101110;
    logic [1:0]  g_exp;
    for (int w = 1; w <= 4; w++) load(2, 8'(8'hC0 + w));
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    refresh();
    for (int c = 0; c < 15; c++) begin
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        load(0, 8'hA1); load(3, 8'hB1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC4); exp_q.push_back(8'hB1);
        refresh();
      end
      g_exp = (c >= 4 && c <= 6) ? 2'd0 : (c >= 12) ? 2'd3 : 2'd2;
      @(negedge clk);
      total++; if (fifo_wr !== wr_pat[c]) begin bad++; $display("FAIL rstmid_wr c=%0d got=%b want=%b", c, fifo_wr, wr_pat[c]); end
      total++; if (busy !== busy_pat[c]) begin bad++; $display("FAIL rstmid_busy c=%0d got=%b want=%b", c, busy, busy_pat[c]); end
      total++; if (req_ready !== (wr_pat[c] ? (4'b0001 << g_exp) : 4'b0000)) begin bad++; $display("FAIL rstmid_ready c=%0d got=%b", c, req_ready); end
      if (busy_pat[c] || c == 4) begin
        total++; if (grant_id !== g_exp) begin bad++; $display("FAIL rstmid_grant c=%0d got=%0d want=%0d", c, grant_id, g_exp); end
      end
      @(posedge clk); #2;
    end
  endtask

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_skip_wrap();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
